bg_manager_axil_slave: RTL
==========================

Name: bg_manager_axil_slave

Overview:
- AXI4-Lite responder for the background manager peripheral. It terminates the writes and reads issued by the processor-side AXI master (VIP master in simulation).
- Holds four 32-bit control registers (control, scroll X, scroll Y, tile base) and exposes them as static configuration to the background renderer.
- Sits between the AXI interconnect and the background rendering pipeline, in the single ACLK domain.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; register index = addr[3:2], addr[5:4] must be 0.
- RESET_TILE_BASE, 32'h0000_0000, reset value of TILE_BASE register.

Ports:
- ACLK  in  1  system clock, all logic rising-edge.
- ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  6  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  6  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- bg_ctrl  out  32  CTRL register (bit0 enable, bits[3:1] palette select).
- bg_scroll_x  out  16  SCROLL_X[15:0].
- bg_scroll_y  out  16  SCROLL_Y[15:0].
- bg_tile_base  out  32  TILE_BASE.

Behaviour:
- Interface: one clock ACLK; reset ARESET is synchronous and active-high.
- Register map:
  - 0x00 CTRL, 0x04 SCROLL_X, 0x08 SCROLL_Y, 0x0C TILE_BASE; all read/write, full 32 bits stored.
  - Addr[1:0] ignored.
- Reset:
  - All AXI outputs are 0 (AWREADY=WREADY=ARREADY=0 during reset, 1 the cycle after release).
  - BRESP=RRESP=OKAY, RDATA=0.
  - CTRL=SCROLL_X=SCROLL_Y=0, TILE_BASE=RESET_TILE_BASE.
  - Any in-flight transaction is dropped; holding registers are cleared.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - AWREADY=1 in W_IDLE and W_HAVE_W. WREADY=1 in W_IDLE and W_HAVE_AW.
  - AW and W may arrive in the same cycle or in either order; each is latched at its handshake edge.
  - Once both are latched (edge k), the write commits at edge k+1, BVALID rises at edge k+1, and the FSM enters W_RESP.
  - In W_RESP, AWREADY=WREADY=0; BVALID is held until BVALID&BREADY, then the FSM returns to W_IDLE.
  - WSTRB[n] gates byte n; WSTRB=0 is a legal no-op with OKAY response.
  - Out-of-range address (addr[5:4]!=0): no register change, BRESP=SLVERR(2'b10).
- Read FSM, states R_IDLE, R_DATA:
  - ARREADY=1 only in R_IDLE.
  - On AR handshake at edge k: RDATA/RRESP registered, RVALID=1 from edge k, state R_DATA.
  - RDATA/RRESP/RVALID are held stable until RREADY, then the FSM returns to R_IDLE. ARREADY reasserts the cycle after the R handshake.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
- Read/write collision:
  - Write and read channels are independent.
  - A read sampled in the same cycle as a write commit to the same register returns the pre-write value.
- Outputs bg_* are driven directly from the registers (without BGM_SHADOW_EN). Changes are visible one cycle after the commit edge.
- The block never generates DECERR; responses are only OKAY or SLVERR.

Optional Feature:
- Macro: BGM_SHADOW_EN.
- Defined:
  - bg_* outputs come from a shadow copy, loaded from the live registers on the edge where frame_start=1.
  - If a write commits on the same edge as frame_start, the shadow takes the pre-write value.
  - AXI reads always return live registers.
  - Shadow resets to the same values as the live registers.
- Undefined: no shadow, frame_start unused, outputs follow the live registers as above.

Test Plan:
- Sequential write/readback: write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C -> all BRESP=OKAY; reads return 0x1..0x4; bg_scroll_x=16'h0002.
- AW 3 cycles before W, and W 2 cycles before AW, to 0x08 with 0xDEADBEEF -> BVALID exactly one cycle after the second handshake; readback 0xDEADBEEF.
- Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID/RDATA stable; AWREADY=WREADY=ARREADY stay 0 until the response handshake.
- WSTRB=4'b0101 writing 0xAABBCCDD to TILE_BASE holding 0x11223344 -> readback 0x11BB33DD.
- Address 0x10 write 0xFFFFFFFF, then read 0x10 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0; registers 0x00-0x0C unchanged.
- ARESET pulsed while BVALID=1 and after CTRL was written 0x7 -> BVALID=0 and CTRL=0 the cycle after reset; with BGM_SHADOW_EN, writing SCROLL_Y=0x40 leaves bg_scroll_y=0 until frame_start, then 0x40.

Source files
------------

// File: rtl/bg_manager_axil_slave.sv
// -----------------------------------------------------------------------------
// bg_manager_axil_slave
//
// AXI4-Lite responder for the background manager peripheral. It holds four
// 32-bit configuration registers and presents them as static configuration
// to the background renderer. Single clock domain (ACLK), synchronous
// active-high reset (ARESET).
//
// Register map (byte address, addr[1:0] ignored, addr[5:4] must be 0):
//   0x00 CTRL       bit0 enable, bits[3:1] palette select, all 32 bits stored
//   0x04 SCROLL_X   bg_scroll_x = SCROLL_X[15:0]
//   0x08 SCROLL_Y   bg_scroll_y = SCROLL_Y[15:0]
//   0x0C TILE_BASE  resets to RESET_TILE_BASE
// Any other address answers SLVERR (reads return 0, writes are dropped).
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*              AXI4-Lite write address/data/response
//   S_AXI_AR*/R*                 AXI4-Lite read address/data
//   S_AXI_AWPROT, S_AXI_ARPROT   accepted and ignored
//   frame_start                  one-cycle pulse at start of vertical blank
//   bg_ctrl, bg_scroll_x,
//   bg_scroll_y, bg_tile_base    configuration to the renderer
//
// Build option:
//   BGM_SHADOW_EN  when defined, bg_* come from a shadow copy of the live
//                  registers that is reloaded on each frame_start pulse, so
//                  the renderer never sees a mid-frame change. Undefined:
//                  bg_* follow the live registers and frame_start is unused.
//
// Write FSM states:
//   state     | meaning
//   W_IDLE    | waiting for AW and W, both ready
//   W_HAVE_AW | address latched, waiting for W
//   W_HAVE_W  | data latched, waiting for AW
//   W_RESP    | commit pending (first cycle) then BVALID held until BREADY
//
// Read FSM states:
//   state     | meaning
//   R_IDLE    | ARREADY high, waiting for AR
//   R_DATA    | RVALID high, RDATA/RRESP held until RREADY
// -----------------------------------------------------------------------------
module bg_manager_axil_slave #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_TILE_BASE    = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            frame_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bg_ctrl,
  output logic [15:0]                     bg_scroll_x,
  output logic [15:0]                     bg_scroll_y,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bg_tile_base
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  w_state_t r_wstate;
  w_state_t w_wstate_nxt;
  r_state_t r_rstate;
  r_state_t w_rstate_nxt;

  // Keeps the ready outputs low while reset is applied and for the reset
  // cycle itself; they rise on the first clock after release.
  logic r_ready_en;

  logic          w_awready;
  logic          w_wready;
  logic          w_arready;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_b_hs;
  logic          w_r_hs;
  logic          w_commit_start;

  logic [3:0]    r_awaddr;   // byte address bits [5:2]
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_commit;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_regs [4];

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_ready_en;
        w_wready  = r_ready_en;
      end
      W_HAVE_AW: w_wready  = r_ready_en;
      W_HAVE_W:  w_awready = r_ready_en;
      default: begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
      end
    endcase
  end

  assign w_aw_hs = S_AXI_AWVALID & w_awready;
  assign w_w_hs  = S_AXI_WVALID & w_wready;
  assign w_b_hs  = r_bvalid & S_AXI_BREADY;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_w_hs)  w_wstate_nxt = W_RESP;
      W_HAVE_W:  if (w_aw_hs) w_wstate_nxt = W_RESP;
      W_RESP:    if (w_b_hs)  w_wstate_nxt = W_IDLE;
      default:   w_wstate_nxt = W_IDLE;
    endcase
  end

  // The edge that latches the last of AW/W only arms the commit; the register
  // update and BVALID happen together on the following edge.
  assign w_commit_start = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  assign w_arready = r_ready_en && (r_rstate == R_IDLE);
  assign w_ar_hs   = S_AXI_ARVALID & w_arready;
  assign w_r_hs    = (r_rstate == R_DATA) & S_AXI_RREADY;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding registers, register file and responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ready_en <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_commit   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_regs[0]  <= '0;
      r_regs[1]  <= '0;
      r_regs[2]  <= '0;
      r_regs[3]  <= RESET_TILE_BASE;
    end else begin
      r_ready_en <= 1'b1;
      r_commit   <= w_commit_start;

      if (w_aw_hs) begin
        r_awaddr <= S_AXI_AWADDR[5:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end

      if (r_commit) begin
        r_bvalid <= 1'b1;
        if (r_awaddr[3:2] == 2'b00) begin
          r_bresp <= RESP_OKAY;
          for (int b = 0; b < SW; b++) begin
            if (r_wstrb[b]) begin
              r_regs[r_awaddr[1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end else begin
          r_bresp <= RESP_SLVERR;
        end
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end

      // Sampled from the register file before any same-edge commit lands.
      if (w_ar_hs) begin
        if (S_AXI_ARADDR[5:4] == 2'b00) begin
          r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

  // ---------------------------------------------------------------------------
  // Renderer configuration outputs
  // ---------------------------------------------------------------------------
`ifdef BGM_SHADOW_EN
  logic [DW-1:0] r_sh_ctrl;
  logic [15:0]   r_sh_scroll_x;
  logic [15:0]   r_sh_scroll_y;
  logic [DW-1:0] r_sh_tile_base;

  // Loaded from the live registers' current contents, so a write committing
  // on the frame_start edge waits for the next frame.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_sh_ctrl      <= '0;
      r_sh_scroll_x  <= '0;
      r_sh_scroll_y  <= '0;
      r_sh_tile_base <= RESET_TILE_BASE;
    end else if (frame_start) begin
      r_sh_ctrl      <= r_regs[0];
      r_sh_scroll_x  <= r_regs[1][15:0];
      r_sh_scroll_y  <= r_regs[2][15:0];
      r_sh_tile_base <= r_regs[3];
    end
  end

  assign bg_ctrl      = r_sh_ctrl;
  assign bg_scroll_x  = r_sh_scroll_x;
  assign bg_scroll_y  = r_sh_scroll_y;
  assign bg_tile_base = r_sh_tile_base;

  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[1:0]};
`else
  assign bg_ctrl      = r_regs[0];
  assign bg_scroll_x  = r_regs[1][15:0];
  assign bg_scroll_y  = r_regs[2][15:0];
  assign bg_tile_base = r_regs[3];

  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[1:0], frame_start};
`endif

endmodule
